// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared definitions for the MUL/DIVU sequencer: ALU control codes, FSM states and op codes.
package alu_muldiv_sequencer_pkg;

  // ALU control codes understood by the shared EX-stage ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_DIV_CMP = 3'd2,
    ST_DIV_SUB = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_DIVU = 1'b1
  } op_e;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL (low product) / DIVU (quotient, remainder) controller that
// borrows the EX-stage ALU one micro-op per cycle (ADD, SUB, SLT only).
// Ports:
//   i_Clk, i_Rst_n         clock, async active-low reset
//   i_Start, i_Op          request (sampled in IDLE only), 0 = MUL, 1 = DIVU
//   i_Op_A, i_Op_B         multiplicand/dividend, multiplier/divisor
//   i_Abort                synchronous flush of the operation in flight
//   o_Busy, o_Done         pipeline stall, one-cycle completion pulse
//   o_Result_Lo/Hi         product low / 0, or quotient / remainder
//   o_Div_By_Zero          divide-by-zero flag, valid with o_Done
//   o_ALU_A/B/Ctrl         ALU operands and control while busy (zeros/ADD otherwise)
//   i_ALU_Result/Zero      combinational ALU result and zero flag
module alu_muldiv_sequencer
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Op,
  input  logic [WIDTH-1:0] i_Op_A,
  input  logic [WIDTH-1:0] i_Op_B,
  input  logic             i_Abort,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Result_Lo,
  output logic [WIDTH-1:0] o_Result_Hi,
  output logic             o_Div_By_Zero,
  output logic [WIDTH-1:0] o_ALU_A,
  output logic [WIDTH-1:0] o_ALU_B,
  output logic [2:0]       o_ALU_Ctrl,
  input  logic [WIDTH-1:0] i_ALU_Result,
  input  logic             i_ALU_Zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // MUL accumulator / DIVU partial remainder R
  logic [WIDTH-1:0]   mcd_q, mcd_d;   // MUL multiplicand MC / DIVU divisor D
  logic [WIDTH-1:0]   mpq_q, mpq_d;   // MUL multiplier MP / DIVU quotient Q
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   div_s;          // R shifted left with Q's MSB brought in
  logic               div_e;          // bit shifted out of R; forces S >= D
  logic [WIDTH-1:0]   q_shl;
  logic [WIDTH-1:0]   mul_acc;
  logic               last_bit;
  logic [CNT_W-1:0]   cnt_inc;
  logic               in_busy;

  assign div_s    = {acc_q[WIDTH-2:0], mpq_q[WIDTH-1]};
  assign div_e    = acc_q[WIDTH-1];
  assign q_shl    = {mpq_q[WIDTH-2:0], 1'b0};
  assign mul_acc  = mpq_q[0] ? i_ALU_Result : acc_q;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign in_busy  = (state_q == ST_MUL) || (state_q == ST_DIV_CMP) || (state_q == ST_DIV_SUB);

  // ALU drive: depends on state and registers only, never on i_Start
  always_comb begin
    o_ALU_A    = '0;
    o_ALU_B    = '0;
    o_ALU_Ctrl = ALU_ADD;
    case (state_q)
      ST_MUL: begin
        o_ALU_A    = acc_q;
        o_ALU_B    = mcd_q;
        o_ALU_Ctrl = ALU_ADD;
      end
      ST_DIV_CMP: begin
        o_ALU_A    = div_s;
        o_ALU_B    = mcd_q;
        o_ALU_Ctrl = ALU_SLT;
      end
      ST_DIV_SUB: begin
        o_ALU_A    = acc_q;
        o_ALU_B    = mcd_q;
        o_ALU_Ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    mpq_d   = mpq_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        // Abort outranks a simultaneous start
        if (!i_Abort && i_Start) begin
          dbz_d = 1'b0;
          cnt_d = '0;
          acc_d = '0;
          if (op_e'(i_Op) == OP_DIVU) begin
            if (i_Op_B == '0) begin
              lo_d    = '1;
              hi_d    = i_Op_A;
              dbz_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              mpq_d   = i_Op_A;
              mcd_d   = i_Op_B;
              state_d = ST_DIV_CMP;
            end
          end else begin
            mcd_d   = i_Op_A;
            mpq_d   = i_Op_B;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_acc;
        mcd_d = {mcd_q[WIDTH-2:0], 1'b0};
        mpq_d = {1'b0, mpq_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
        if (last_bit) begin
          lo_d    = mul_acc;
          hi_d    = '0;
          state_d = ST_DONE;
        end
      end
      ST_DIV_CMP: begin
        acc_d = div_s;
        // SLT result zero means S >= D
        if (div_e || i_ALU_Zero) begin
          mpq_d   = q_shl | WIDTH'(1);
          state_d = ST_DIV_SUB;
        end else begin
          mpq_d = q_shl;
          cnt_d = cnt_inc;
          if (last_bit) begin
            lo_d    = q_shl;
            hi_d    = div_s;
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV_SUB: begin
        // Modulo subtraction stays correct when the 17th bit was shifted out
        acc_d = i_ALU_Result;
        cnt_d = cnt_inc;
        if (last_bit) begin
          lo_d    = mpq_q;
          hi_d    = i_ALU_Result;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV_CMP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flush beats completion: no DONE, results untouched
    if (in_busy && i_Abort) begin
      state_d = ST_IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbz_d   = dbz_q;
    end
  end

  assign busy_d = (state_d == ST_MUL) || (state_d == ST_DIV_CMP) || (state_d == ST_DIV_SUB);
  assign done_d = (state_d == ST_DONE);

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mcd_q   <= '0;
      mpq_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      mpq_q   <= mpq_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_Busy        = busy_q;
  assign o_Done        = done_q;
  assign o_Result_Lo   = lo_q;
  assign o_Result_Hi   = hi_q;
  assign o_Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with a behavioural model of the shared ALU.
module tb_alu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        abort = 1'b0;
  logic        busy, done, dbz;
  logic [15:0] res_lo, res_hi;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Shared EX-stage ALU (SLT is an unsigned compare)
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_res = alu_a + alu_b;
      3'b001:  alu_res = alu_a - alu_b;
      3'b101:  alu_res = alu_a & alu_b;
      3'b110:  alu_res = alu_a | alu_b;
      3'b111:  alu_res = 16'(alu_a < alu_b);
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == 16'h0000);

  alu_muldiv_sequencer dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Start      (start),
    .i_Op         (op),
    .i_Op_A       (op_a),
    .i_Op_B       (op_b),
    .i_Abort      (abort),
    .o_Busy       (busy),
    .o_Done       (done),
    .o_Result_Lo  (res_lo),
    .o_Result_Hi  (res_hi),
    .o_Div_By_Zero(dbz),
    .o_ALU_A      (alu_a),
    .o_ALU_B      (alu_b),
    .o_ALU_Ctrl   (alu_ctrl),
    .i_ALU_Result (alu_res),
    .i_ALU_Zero   (alu_zero)
  );

  // Issue one op and wait for o_Done; cyc counts edges from the sampling edge (1 = first),
  // or -1 if o_Done never arrives.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input bit repulse, output int cyc, output int busy_cyc,
                        output int non_add);
    cyc = 0; busy_cyc = 0; non_add = 0;
    op = o; op_a = a; op_b = b; start = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (repulse && cyc == 3) begin start = 1'b1; op_a = 16'h0003; op_b = 16'h0003; end
      if (repulse && cyc == 4) start = 1'b0;
      if (busy) begin
        busy_cyc++;
        if (alu_ctrl != 3'b000) non_add++;
      end
      if (done) break;
      if (cyc > 60) begin cyc = -1; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b done=%b dbz=%b exp 0 0 0", busy, done, dbz); end
    n_tests++; if (res_lo !== 16'h0 || res_hi !== 16'h0) begin n_fail++; $display("FAIL reset_results got lo=%h hi=%h exp 0000 0000", res_lo, res_hi); end
    n_tests++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_ctrl !== 3'b000) begin n_fail++; $display("FAIL reset_alu got a=%h b=%h ctrl=%b exp 0 0 000", alu_a, alu_b, alu_ctrl); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_basic();
    int cyc, bc, na;
    run_op(1'b0, 16'd7, 16'd9, 1'b0, cyc, bc, na);
    n_tests++; if (cyc !== 17) begin n_fail++; $display("FAIL mul7x9_latency got %0d exp 17", cyc); end
    n_tests++; if (bc !== 16) begin n_fail++; $display("FAIL mul7x9_busy_cycles got %0d exp 16", bc); end
    n_tests++; if (na !== 0) begin n_fail++; $display("FAIL mul7x9_alu_ctrl non-ADD cycles got %0d exp 0", na); end
    n_tests++; if (res_lo !== 16'h003F || res_hi !== 16'h0000) begin n_fail++; $display("FAIL mul7x9_result got lo=%h hi=%h exp 003f 0000", res_lo, res_hi); end
    n_tests++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_ctrl !== 3'b000) begin n_fail++; $display("FAIL done_alu_idle got a=%h b=%h ctrl=%b exp 0 0 000", alu_a, alu_b, alu_ctrl); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_mul_max();
    int cyc, bc, na;
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, cyc, bc, na);
    n_tests++; if (cyc !== 17) begin n_fail++; $display("FAIL mulmax_latency got %0d exp 17", cyc); end
    n_tests++; if (res_lo !== 16'h0001 || res_hi !== 16'h0000) begin n_fail++; $display("FAIL mulmax_result got lo=%h hi=%h exp 0001 0000", res_lo, res_hi); end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mulmax_no_requeue got busy=%b exp 0", busy); end
  endtask

  task automatic test_div();
    logic [15:0] a_t [3] = '{16'd100, 16'hFFFF, 16'd5};
    logic [15:0] b_t [3] = '{16'd7,   16'h8001, 16'd9};
    logic [15:0] q_t [3] = '{16'd14,  16'h0001, 16'd0};
    logic [15:0] r_t [3] = '{16'd2,   16'h7FFE, 16'd5};
    int          l_t [3] = '{20, 18, 17};
    int cyc, bc, na;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, a_t[i], b_t[i], 1'b0, cyc, bc, na);
      n_tests++; if (cyc !== l_t[i]) begin n_fail++; $display("FAIL div%0d_latency got %0d exp %0d", i, cyc, l_t[i]); end
      n_tests++; if (res_lo !== q_t[i] || res_hi !== r_t[i] || dbz !== 1'b0) begin n_fail++; $display("FAIL div%0d_result got q=%h r=%h dbz=%b exp q=%h r=%h dbz=0", i, res_lo, res_hi, dbz, q_t[i], r_t[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_by_zero();
    int cyc, bc, na;
    run_op(1'b1, 16'h1234, 16'h0000, 1'b0, cyc, bc, na);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL dbz_latency got %0d exp 1", cyc); end
    n_tests++; if (res_lo !== 16'hFFFF || res_hi !== 16'h1234 || dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_result got lo=%h hi=%h dbz=%b exp ffff 1234 1", res_lo, res_hi, dbz); end
    @(posedge clk); #1;
    n_tests++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_hold got %b exp 1", dbz); end
    run_op(1'b0, 16'd2, 16'd3, 1'b0, cyc, bc, na);
    n_tests++; if (cyc !== 17 || res_lo !== 16'd6 || res_hi !== 16'd0 || dbz !== 1'b0) begin n_fail++; $display("FAIL dbz_then_mul got cyc=%0d lo=%h hi=%h dbz=%b exp 17 0006 0000 0", cyc, res_lo, res_hi, dbz); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int cyc, bc, na;
    bit seen_done;
    run_op(1'b0, 16'd4, 16'd5, 1'b0, cyc, bc, na);
    @(posedge clk); #1;
    // Abort together with start in IDLE: request dropped
    op = 1'b0; op_a = 16'd5; op_b = 16'd5; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_start got busy=%b exp 0", busy); end
    // Abort at busy cycle 5 of a MUL
    op = 1'b0; op_a = 16'h0ABC; op_b = 16'h0077; start = 1'b1;
    seen_done = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 5) abort = 1'b1;
      if (c == 6) begin
        abort = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_to_idle got busy=%b exp 0", busy); end
      end
      if (done) seen_done = 1'b1;
    end
    n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got done seen=%b exp 0", seen_done); end
    n_tests++; if (res_lo !== 16'd20 || res_hi !== 16'd0) begin n_fail++; $display("FAIL abort_results_kept got lo=%h hi=%h exp 0014 0000", res_lo, res_hi); end
    run_op(1'b0, 16'h1111, 16'd3, 1'b0, cyc, bc, na);
    n_tests++; if (cyc !== 17 || res_lo !== 16'h3333) begin n_fail++; $display("FAIL abort_next_mul got cyc=%0d lo=%h exp 17 3333", cyc, res_lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div();
    int cyc, bc, na;
    bit seen_done = 1'b0;
    op = 1'b1; op_a = 16'd100; op_b = 16'd7; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_div_flags got busy=%b done=%b seen=%b exp 0 0 0", busy, done, seen_done); end
    n_tests++; if (res_lo !== 16'h0 || res_hi !== 16'h0 || dbz !== 1'b0) begin n_fail++; $display("FAIL rst_mid_div_results got lo=%h hi=%h dbz=%b exp 0000 0000 0", res_lo, res_hi, dbz); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 16'd100, 16'd7, 1'b0, cyc, bc, na);
    n_tests++; if (cyc !== 20 || res_lo !== 16'd14 || res_hi !== 16'd2) begin n_fail++; $display("FAIL rst_next_div got cyc=%0d q=%h r=%h exp 20 000e 0002", cyc, res_lo, res_hi); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div();
    test_div_by_zero();
    test_abort();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
